// File: rtl/truth_seq_pkg.sv
// Shared types and sizing helpers for the truth-table sequencer.
package truth_seq_pkg;

    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_RUN  = 2'd1,
        TS_DONE = 2'd2
    } ts_state_e;

    localparam int TS_MAX_N_IN = 6;

    // Number of truth-table entries (and bits) for an n_in-input function.
    function automatic int ts_table_width(input int n_in);
        return 32'sd1 << n_in;
    endfunction

endpackage

// File: rtl/truth_seq_param_check.sv
// Elaboration-time legality check of the sequencer parameters.
module truth_seq_param_check
    import truth_seq_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) ();

    if ((N_IN < 1) || (N_IN > TS_MAX_N_IN)) begin : g_bad_n_in
        $error("truth_table_sequencer: N_IN=%0d outside 1..%0d", N_IN, TS_MAX_N_IN);
    end

    if (SETTLE < 1) begin : g_bad_settle
        $error("truth_table_sequencer: SETTLE=%0d must be at least 1", SETTLE);
    end

endmodule

// File: rtl/truth_seq_settle_timer.sv
// Loadable down-counter that paces each vector; zero marks the sample cycle.
module truth_seq_settle_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sweep of a small combinational DUT.
// Optional comparator against an expected table: define TRUTH_SEQ_COMPARE_EN.
module truth_table_sequencer
    import truth_seq_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              resp,
`ifdef TRUTH_SEQ_COMPARE_EN
    input  logic [ts_table_width(N_IN)-1:0]   expected,
    output logic                              pass,
    output logic [N_IN:0]                     mismatch_cnt,
`endif
    output logic [N_IN-1:0]                   stim,
    output logic                              busy,
    output logic                              done,
    output logic [ts_table_width(N_IN)-1:0]   table_q
);

    localparam int TBL_W = ts_table_width(N_IN);
    localparam int TMR_W = $clog2(SETTLE) + 1;
    localparam logic [N_IN-1:0]  STIM_LAST  = N_IN'(TBL_W - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE - 1);

    truth_seq_param_check #(.N_IN(N_IN), .SETTLE(SETTLE)) u_param_check ();

    ts_state_e          state_r;
    logic [N_IN-1:0]    stim_r;
    logic               busy_r;
    logic               done_r;
    logic [TBL_W-1:0]   table_r;

    logic               settle_zero_s;
    logic               sample_s;
    logic               terminal_s;
    logic               timer_load_s;
    logic               timer_dec_s;

`ifdef TRUTH_SEQ_COMPARE_EN
    logic [TBL_W-1:0]   expected_r;
    logic               pass_r;
    logic [N_IN:0]      mism_r;
    logic               diff_s;
    logic [N_IN:0]      mism_next_s;

    assign diff_s      = resp ^ expected_r[stim_r];
    assign mism_next_s = mism_r + {{N_IN{1'b0}}, diff_s};
`endif

    assign sample_s   = (state_r == TS_RUN) && settle_zero_s;
    // Terminal detection is an explicit compare so stim never relies on wrap.
    assign terminal_s = (stim_r == STIM_LAST);

    // Timer control: reload on acceptance and after every non-final sample.
    always_comb begin
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        if ((state_r == TS_IDLE) && start) begin
            timer_load_s = 1'b1;
        end else if (sample_s && !terminal_s) begin
            timer_load_s = 1'b1;
        end else begin
            timer_dec_s = (state_r == TS_RUN) && !settle_zero_s;
        end
    end

    truth_seq_settle_timer #(.WIDTH(TMR_W)) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (SETTLE_LD),
        .dec      (timer_dec_s),
        .zero     (settle_zero_s)
    );

    // Sweep FSM with vector counter, table capture and comparator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= TS_IDLE;
            stim_r     <= {N_IN{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            table_r    <= {TBL_W{1'b0}};
`ifdef TRUTH_SEQ_COMPARE_EN
            expected_r <= {TBL_W{1'b0}};
            pass_r     <= 1'b0;
            mism_r     <= {(N_IN+1){1'b0}};
`endif
        end else begin
            case (state_r)
                TS_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= TS_RUN;
                        busy_r     <= 1'b1;
                        stim_r     <= {N_IN{1'b0}};
                        table_r    <= {TBL_W{1'b0}};
`ifdef TRUTH_SEQ_COMPARE_EN
                        expected_r <= expected;
                        pass_r     <= 1'b0;
                        mism_r     <= {(N_IN+1){1'b0}};
`endif
                    end else begin
                        state_r <= TS_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                TS_RUN: begin
                    if (settle_zero_s) begin
                        table_r[stim_r] <= resp;
`ifdef TRUTH_SEQ_COMPARE_EN
                        mism_r <= mism_next_s;
`endif
                        if (terminal_s) begin
                            state_r <= TS_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
`ifdef TRUTH_SEQ_COMPARE_EN
                            pass_r  <= (mism_next_s == {(N_IN+1){1'b0}});
`endif
                        end else begin
                            stim_r <= stim_r + {{(N_IN-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_r <= TS_RUN;
                    end
                end
                TS_DONE: begin
                    state_r <= TS_IDLE;
                    done_r  <= 1'b0;
                    stim_r  <= {N_IN{1'b0}};
                end
                default: begin
                    state_r <= TS_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    stim_r  <= {N_IN{1'b0}};
                end
            endcase
        end
    end

    assign stim    = stim_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign table_q = table_r;
`ifdef TRUTH_SEQ_COMPARE_EN
    assign pass         = pass_r;
    assign mismatch_cnt = mism_r;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: four sequencer configurations driven by table-defined DUT functions.
module tb_truth_table_sequencer;

    typedef struct {
        int          id;
        logic [63:0] tbl;
        int          done_cyc;
        int          mism;
    } exp_t;

    exp_t        sb[$];
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  start = 4'b0000;
    logic [63:0] fn [4];
    logic [63:0] expv [4];
    int          ni_of [4] = '{2, 3, 1, 6};
    int          st_of [4] = '{1, 3, 1, 2};
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [1:0]  stim0;  logic [2:0] stim1;  logic [0:0] stim2;  logic [5:0] stim3;
    logic [3:0]  tbl0;   logic [7:0] tbl1;   logic [1:0] tbl2;   logic [63:0] tbl3;
    logic [3:0]  busy, done;
    logic [3:0]  resp;
    logic [3:0]  pass;
    logic [2:0]  mism0;  logic [3:0] mism1;  logic [1:0] mism2;  logic [6:0] mism3;

    assign resp[0] = fn[0][stim0];
    assign resp[1] = fn[1][stim1];
    assign resp[2] = fn[2][stim2];
    assign resp[3] = fn[3][stim3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .resp(resp[0]),
`ifdef TRUTH_SEQ_COMPARE_EN
        .expected(expv[0][3:0]), .pass(pass[0]), .mismatch_cnt(mism0),
`endif
        .stim(stim0), .busy(busy[0]), .done(done[0]), .table_q(tbl0));
    truth_table_sequencer #(.N_IN(3), .SETTLE(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .resp(resp[1]),
`ifdef TRUTH_SEQ_COMPARE_EN
        .expected(expv[1][7:0]), .pass(pass[1]), .mismatch_cnt(mism1),
`endif
        .stim(stim1), .busy(busy[1]), .done(done[1]), .table_q(tbl1));
    truth_table_sequencer #(.N_IN(1), .SETTLE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .resp(resp[2]),
`ifdef TRUTH_SEQ_COMPARE_EN
        .expected(expv[2][1:0]), .pass(pass[2]), .mismatch_cnt(mism2),
`endif
        .stim(stim2), .busy(busy[2]), .done(done[2]), .table_q(tbl2));
    truth_table_sequencer #(.N_IN(6), .SETTLE(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .resp(resp[3]),
`ifdef TRUTH_SEQ_COMPARE_EN
        .expected(expv[3]), .pass(pass[3]), .mismatch_cnt(mism3),
`endif
        .stim(stim3), .busy(busy[3]), .done(done[3]), .table_q(tbl3));

    function automatic logic [63:0] stim_of(input int i);
        case (i)
            0: return 64'(stim0);
            1: return 64'(stim1);
            2: return 64'(stim2);
            default: return 64'(stim3);
        endcase
    endfunction

    function automatic logic [63:0] tbl_of(input int i);
        case (i)
            0: return 64'(tbl0);
            1: return 64'(tbl1);
            2: return 64'(tbl2);
            default: return tbl3;
        endcase
    endfunction

    function automatic logic [63:0] mism_of(input int i);
        case (i)
            0: return 64'(mism0);
            1: return 64'(mism1);
            2: return 64'(mism2);
            default: return 64'(mism3);
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int i);
        return (ni_of[i] == 6) ? {64{1'b1}} : ((64'd1 << (1 << ni_of[i])) - 64'd1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding sweep.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk($sformatf("spurious_done_u%0d", i), 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_instance", 64'(i), 64'(e.id));
                    chk($sformatf("done_cycle_u%0d", i), 64'(cyc), 64'(e.done_cyc));
                    chk($sformatf("table_u%0d", i), tbl_of(i), e.tbl);
`ifdef TRUTH_SEQ_COMPARE_EN
                    chk($sformatf("mismatch_u%0d", i), mism_of(i), 64'(e.mism));
                    chk($sformatf("pass_u%0d", i), 64'(pass[i]), 64'(e.mism == 0));
`endif
                end
            end
        end
    end

    // One sweep: drive start, then check stim/busy every cycle against j/SETTLE.
    task automatic run_sweep(input int id, input logic [63:0] f, input logic [63:0] ex, input bit poke);
        int n, s, t, e0;
        logic [63:0] m, exp_stim;
        exp_t e;
        n = ni_of[id]; s = st_of[id]; t = (1 << n) * s; m = mask_of(id);
        fn[id] = f & m;
        @(negedge clk);
        start[id] = 1'b1;
        expv[id]  = ex & m;
        @(negedge clk);
        start[id] = 1'b0;
        expv[id]  = ~ex;
        e0 = cyc;
        e.id = id; e.tbl = f & m; e.done_cyc = e0 + t; e.mism = $countones((f ^ ex) & m);
        sb.push_back(e);
        for (int j = 0; j <= t + 2; j++) begin
            if (j > 0) @(negedge clk);
            start[id] = poke && ((j == 1) || (j == t));
            if (j < t)       exp_stim = 64'(j / s);
            else if (j == t) exp_stim = 64'((1 << n) - 1);
            else             exp_stim = 64'd0;
            chk($sformatf("stim_u%0d_j%0d", id, j), stim_of(id), exp_stim);
            chk($sformatf("busy_u%0d_j%0d", id, j), 64'(busy[id]), 64'(j < t));
        end
        start[id] = 1'b0;
        chk($sformatf("table_hold_u%0d", id), tbl_of(id), f & m);
`ifdef TRUTH_SEQ_COMPARE_EN
        chk($sformatf("pass_hold_u%0d", id), 64'(pass[id]), 64'(e.mism == 0));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_stim_u%0d", tag, i), stim_of(i), 64'd0);
            chk($sformatf("%s_busy_u%0d", tag, i), 64'(busy[i]), 64'd0);
            chk($sformatf("%s_done_u%0d", tag, i), 64'(done[i]), 64'd0);
            chk($sformatf("%s_table_u%0d", tag, i), tbl_of(i), 64'd0);
`ifdef TRUTH_SEQ_COMPARE_EN
            chk($sformatf("%s_pass_u%0d", tag, i), 64'(pass[i]), 64'd0);
            chk($sformatf("%s_mism_u%0d", tag, i), mism_of(i), 64'd0);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            fn[i] = 64'd0;
            expv[i] = 64'd0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_sweep(0, 64'b1000, 64'b1000, 1'b0);          // AND
        run_sweep(0, 64'b1110, 64'b0110, 1'b0);          // OR vs XOR
        run_sweep(1, 64'b11101000, 64'b11101000, 1'b0);  // majority
        run_sweep(0, 64'b0110, 64'b0110, 1'b1);          // ignored starts

        // Reset after the second sample wipes the partial table.
        fn[0] = 64'hF;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_table_u0", 64'(tbl0), 64'b0011);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        if (sb.size() == 0) begin
            @(negedge clk);
            rst_n = 1'b1;
            run_sweep(0, 64'b1000, 64'b1000, 1'b0);
        end else begin
            chk("midreset_scoreboard", 64'(sb.size()), 64'd0);
        end
        rst_n = 1'b1;

        run_sweep(2, 64'b01, 64'b01, 1'b0);              // NOT, terminal without wrap
        run_sweep(3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int id;
            logic [63:0] f, ex;
            id = int'($urandom_range(0, 2));
            f  = {$urandom, $urandom};
            ex = ($urandom_range(0, 1) == 0) ? f : (f ^ (64'd1 << $urandom_range(0, (1 << ni_of[id]) - 1)));
            run_sweep(id, f, ex, bit'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("pending_done", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Parametrised exhaustive truth-table sequencer for small combinational blocks. On `start` it applies every input combination of an `N_IN`-input function to the device under test, waits a programmable settle time per vector, and captures each one-bit response into a `2**N_IN`-bit truth-table register. An optional comparator checks the captured table against an expected table and reports pass/fail plus a mismatch count. It lives in the lab self-check harness, next to the gate-level designs it exercises.

## Interface
- `N_IN`, default 2: number of DUT inputs; legal range 1..6.
- `SETTLE`, default 1: clock cycles each vector is held before its response is sampled; minimum 1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `resp`  in  1  DUT output for the vector currently on `stim`.
- `stim`  out  N_IN  vector driven to the DUT.
- `busy`  out  1  high from the cycle after start acceptance through the final sample.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `table_q`  out  2**N_IN  captured responses; bit i holds the response to `stim == i`.
- `expected`  in  2**N_IN  reference table; present only with `TRUTH_SEQ_COMPARE_EN`.
- `pass`  out  1  table matched; present only with `TRUTH_SEQ_COMPARE_EN`.
- `mismatch_cnt`  out  N_IN+1  count of differing bits; present only with `TRUTH_SEQ_COMPARE_EN`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE -> RUN when `start=1`.
  - RUN -> DONE on the sample of vector `2**N_IN-1`.
  - DONE -> IDLE unconditionally after one cycle.
- **Start acceptance:** in IDLE with `start=1`, the next edge sets `stim=0`, loads `settle_cnt=SETTLE-1`, clears `table_q`, `pass` and `mismatch_cnt`, and captures `expected` into an internal register. `expected` is then ignored for the rest of the sweep.
- **RUN:**
  - While `settle_cnt != 0`, decrement it.
  - When `settle_cnt == 0`, the edge writes `table_q[stim] <= resp`.
  - If `stim` is not terminal, increment `stim` and reload `settle_cnt`.
  - The terminal test is an explicit compare against `2**N_IN-1`, never counter wrap. `stim` holds its final value into DONE.
- **DONE:** `done=1` for exactly one cycle. `pass = (mismatch_cnt == 0)` is stable from this cycle. After DONE, `stim` returns to 0.
- **Result hold:** `table_q`, `pass` and `mismatch_cnt` hold until the next accepted start.
- **Ignored starts:** `start` in RUN or DONE is ignored; it is not queued.
- **Reset:** `rst_n=0` at any time, including mid-sweep, asynchronously forces IDLE. All outputs (`stim`, `busy`, `done`, `table_q`, `pass`, `mismatch_cnt`) go to 0. No partial result survives.

## Timing
- Start accepted at edge E0.
- Vector k is sampled at edge E0 + (k+1)·SETTLE.
- DONE begins after the final sample, so `done` is high in the cycle after edge E0 + 2**N_IN·SETTLE.
- `busy` is a registered output, high from E0 to the final sample edge.
- `stim` changes only on sample edges, which gives the DUT SETTLE full cycles per vector.
- `resp` is sampled synchronously. The DUT path must settle within SETTLE cycles.

## Configuration
- `TRUTH_SEQ_COMPARE_EN` defined: the `expected` port, the expected-capture register, the per-sample comparator and the `pass`/`mismatch_cnt` outputs are present. At each sample, `mismatch_cnt` increments when `resp != expected_q[stim]`.
- Not defined: those ports and all associated logic are absent. The block only captures `table_q`.

## Structure
- **Shared package `truth_seq_pkg`** holds:
  - FSM state enum (`TS_IDLE`, `TS_RUN`, `TS_DONE`).
  - `TS_MAX_N_IN = 6`.
  - A width function for `2**N_IN`.
- **Elaboration checks:** assert `1 <= N_IN <= TS_MAX_N_IN` and `SETTLE >= 1`.
- **Sub-module:** one natural sub-module, `truth_seq_settle_timer`. It is a down-counter with load and a zero flag; width is clog2(SETTLE)+1.
- **Top level:** FSM, vector counter, table register, comparator.

## Test plan
- N_IN=2, SETTLE=1, resp = AND(stim), expected=4'b1000 -> `table_q=4'b1000`, `pass=1`, `mismatch_cnt=0`, `done` one cycle after edge E0+4.
- N_IN=2, resp = OR(stim), expected=4'b0110 (XOR) -> `table_q=4'b1110`, `mismatch_cnt=1`, `pass=0`.
- N_IN=3, SETTLE=3, resp = majority -> `table_q=8'b11101000`, `done` after edge E0+24, each `stim` value held exactly 3 cycles.
- `start` pulsed mid-RUN and in the DONE cycle -> no restart. A single sweep completes, `done` pulses once, `table_q` is unchanged.
- `rst_n` low after the 2nd sample -> all outputs 0 immediately. A fresh start then produces a full correct table.
- N_IN=1, SETTLE=1, resp = ~stim -> `table_q=2'b01`, `done` after edge E0+2; confirms the terminal compare does not wrap.
